// File: rtl/trace_capture_buffer.sv
// Execution trace capture unit. Retired-instruction samples go into a circular buffer.
// A programmable trigger ends the capture, and the history is then read back oldest-first.
module trace_capture_buffer #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 24,
  parameter int FLAG_W  = 4,
  parameter int DEPTH   = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rstb,
  input  logic                              i_clk_en,
  input  logic                              i_arm,
  input  logic                              i_stop,
  input  logic [1:0]                        i_mode,
  input  logic [PC_W-1:0]                   i_trig_pc,
  input  logic [FLAG_W-1:0]                 i_trig_mask,
  input  logic [$clog2(DEPTH)-1:0]          i_post,
  input  logic                              i_valid,
  input  logic [PC_W-1:0]                   i_pc,
  input  logic [INSTR_W-1:0]                i_instr,
  input  logic [FLAG_W-1:0]                 i_flags,
  input  logic                              i_rd_en,
  output logic [FLAG_W+INSTR_W+PC_W-1:0]    o_rd_data,
  output logic                              o_rd_valid,
  output logic [1:0]                        o_state,
  output logic [$clog2(DEPTH):0]            o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = FLAG_W + INSTR_W + PC_W;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH;

  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, POST = 2'b10, DONE = 2'b11} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] post_cnt;
  logic [AW-1:0] post_q;
  logic [1:0]    mode_q;
  logic [AW:0]   count;
  logic [DW-1:0] mem [DEPTH];

  logic          trig_hit;
  logic          wr_fire;
  logic          rd_fire;
  logic          to_done;
  logic          to_post;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW:0]   count_nxt;

  always_comb begin
    trig_hit = 1'b0;
    case (mode_q)
      2'b00:   trig_hit = (i_pc == i_trig_pc);
      2'b01:   trig_hit = 1'b1;
      2'b10:   trig_hit = |(i_flags & i_trig_mask);
      default: trig_hit = 1'b0;
    endcase
  end

  // Arm wins over everything else in the same cycle, so it suppresses writes and reads.
  always_comb begin
    wr_fire    = i_clk_en && !i_arm && (state == ARMED || state == POST) && i_valid;
    rd_fire    = i_clk_en && !i_arm && (state == DONE) && i_rd_en && (count != '0);
    wr_ptr_nxt = wr_fire ? wr_ptr + PTR_ONE : wr_ptr;
    count_nxt  = (wr_fire && count != CNT_FULL) ? count + CNT_ONE : count;
    to_done    = 1'b0;
    to_post    = 1'b0;
    if (state == ARMED) begin
      to_done = i_stop || (i_valid && trig_hit && post_q == '0);
      to_post = !i_stop && i_valid && trig_hit && post_q != '0;
    end else if (state == POST) begin
      to_done = i_stop || (i_valid && post_cnt == PTR_ONE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_fire)
      mem[wr_ptr] <= {i_flags, i_instr, i_pc};
  end

  // On entering DONE, the read pointer is set to the oldest entry: the post-write pointer minus the post-write count.
  // A full count wraps to zero, which leaves rd_ptr equal to wr_ptr.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      post_cnt   <= '0;
      post_q     <= '0;
      mode_q     <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else if (i_clk_en) begin
      if (i_arm) begin
        state      <= ARMED;
        wr_ptr     <= '0;
        count      <= '0;
        post_cnt   <= '0;
        post_q     <= i_post;
        mode_q     <= i_mode;
        o_rd_valid <= 1'b0;
      end else begin
        o_rd_valid <= rd_fire;
        wr_ptr     <= wr_ptr_nxt;
        if (rd_fire) begin
          o_rd_data <= mem[rd_ptr];
          rd_ptr    <= rd_ptr + PTR_ONE;
          count     <= count - CNT_ONE;
        end else begin
          count <= count_nxt;
        end
        if (to_done) begin
          state  <= DONE;
          rd_ptr <= wr_ptr_nxt - count_nxt[AW-1:0];
        end else if (to_post) begin
          state    <= POST;
          post_cnt <= post_q;
        end else if (state == POST && i_valid) begin
          post_cnt <= post_cnt - PTR_ONE;
        end
      end
    end
  end

  assign o_state = state;
  assign o_count = count;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Self-checking bench for trace_capture_buffer.
// Directed and random captures are compared against a queue-based model of the trace history.
module tb_trace_capture_buffer;

  localparam int PC_W = 16, INSTR_W = 24, FLAG_W = 4, DEPTH = 16, AW = 4;
  localparam int DW = FLAG_W + INSTR_W + PC_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clk_en, arm, stop, valid, rd_en;
  logic [1:0]        mode;
  logic [PC_W-1:0]   trig_pc, pc;
  logic [FLAG_W-1:0] mask, flags;
  logic [AW-1:0]     post;
  logic [INSTR_W-1:0] instr;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic [1:0]        state;
  logic [AW:0]       count;

  int errors = 0;
  int checks = 0;

  // Model: the stored trace is simply the last DEPTH accepted samples, oldest at the front.
  logic [DW-1:0] m_q[$];
  int            m_state;
  int            m_left;
  logic [AW-1:0] m_post;
  logic [1:0]    m_mode;
  logic          m_exp_valid;
  logic [DW-1:0] m_exp_data;

  trace_capture_buffer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rstb(rst_n), .i_clk_en(clk_en), .i_arm(arm), .i_stop(stop),
    .i_mode(mode), .i_trig_pc(trig_pc), .i_trig_mask(mask), .i_post(post),
    .i_valid(valid), .i_pc(pc), .i_instr(instr), .i_flags(flags), .i_rd_en(rd_en),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_state(state), .o_count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    m_q.delete();
    m_state     = 0;
    m_exp_valid = 1'b0;
    m_exp_data  = '0;
  endtask

  task automatic model_edge();
    bit hit;
    if (!clk_en) return;
    if (arm) begin
      m_q.delete();
      m_state = 1; m_post = post; m_mode = mode; m_exp_valid = 1'b0;
      return;
    end
    m_exp_valid = 1'b0;
    if (m_state == 3) begin
      if (rd_en && m_q.size() > 0) begin
        m_exp_data  = m_q.pop_front();
        m_exp_valid = 1'b1;
      end
    end else if (m_state == 1 || m_state == 2) begin
      if (valid) begin
        m_q.push_back({flags, instr, pc});
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
      end
      hit = valid && ((m_mode == 2'd0) ? (pc == trig_pc) :
                      (m_mode == 2'd1) ? 1'b1 :
                      (m_mode == 2'd2) ? ((flags & mask) != 0) : 1'b0);
      if (stop) m_state = 3;
      else if (m_state == 1 && hit) begin
        if (m_post == 0) m_state = 3;
        else begin m_state = 2; m_left = int'(m_post); end
      end else if (m_state == 2 && valid) begin
        m_left--;
        if (m_left == 0) m_state = 3;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [PC_W-1:0] p, input logic [FLAG_W-1:0] f);
    valid = v; pc = p; flags = f; instr = INSTR_W'($urandom());
    tick();
    valid = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] md, input logic [AW-1:0] pst);
    mode = md; post = pst; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks += 4;
    if (state !== 2'b00)  begin errors++; $display("[TB] FAIL reset_state: got %0h expected 0", state); end
    if (count !== '0)     begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", rd_valid); end
    if (rd_data !== '0)   begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", rd_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mode_immediate();
    do_arm(2'b01, 4'd3);
    for (int p = 'h100; p <= 'h105; p++) present(1'b1, PC_W'(p), 4'h0);
    checks += 2;
    if (state !== 2'b11) begin errors++; $display("[TB] FAIL imm_state: got %0h expected 3", state); end
    if (count !== 5'd4)  begin errors++; $display("[TB] FAIL imm_count: got %0d expected 4", count); end
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      tick();
      checks++;
      if (i < 4) begin
        if (rd_valid !== 1'b1 || rd_data[PC_W-1:0] !== PC_W'('h100 + i) || rd_data !== m_exp_data) begin
          errors++;
          $display("[TB] FAIL imm_read%0d: got v=%0b %0h expected v=1 pc=%0h", i, rd_valid, rd_data, 'h100 + i);
        end
      end else if (rd_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL imm_empty_read: got v=%0b expected 0", rd_valid);
      end
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL imm_pulse: got %0b expected 0", rd_valid); end
  endtask

  task automatic test_mode_pc_wrap();
    trig_pc = 16'h0020;
    do_arm(2'b00, 4'd2);
    for (int p = 0; p <= 'h30; p++) present(1'b1, PC_W'(p), 4'h0);
    checks += 2;
    if (state !== 2'b11) begin errors++; $display("[TB] FAIL pc_state: got %0h expected 3", state); end
    if (count !== 5'd16) begin errors++; $display("[TB] FAIL pc_count: got %0d expected 16", count); end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data[PC_W-1:0] !== PC_W'('h13 + i) || rd_data !== m_exp_data) begin
        errors++;
        $display("[TB] FAIL pc_read%0d: got v=%0b %0h expected pc=%0h data=%0h", i, rd_valid, rd_data, 'h13 + i, m_exp_data);
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_mode_flag();
    mask = 4'b0100;
    do_arm(2'b10, 4'd0);
    for (int p = 0; p <= 7; p++) present(1'b1, PC_W'(p), (p == 7) ? 4'b0100 : 4'b0000);
    checks += 2;
    if (state !== 2'b11) begin errors++; $display("[TB] FAIL flag_state: got %0h expected 3", state); end
    if (count !== 5'd8)  begin errors++; $display("[TB] FAIL flag_count: got %0d expected 8", count); end
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== m_exp_data) begin
        errors++; $display("[TB] FAIL flag_read%0d: got v=%0b %0h expected %0h", i, rd_valid, rd_data, m_exp_data);
      end
    end
    rd_en = 1'b0;
    checks++;
    if (rd_data[PC_W-1:0] !== 16'h0007 || rd_data[DW-1:DW-FLAG_W] !== 4'b0100) begin
      errors++; $display("[TB] FAIL flag_last: got %0h expected pc=7 flags=4", rd_data);
    end
    tick();
  endtask

  task automatic test_manual_and_arm_priority();
    do_arm(2'b11, AW'($urandom()));
    for (int i = 0; i < 5; i++) present(1'b1, PC_W'('h40 + i), 4'hF);
    stop = 1'b1; tick(); stop = 1'b0;
    checks += 2;
    if (state !== 2'b11) begin errors++; $display("[TB] FAIL man_state: got %0h expected 3", state); end
    if (count !== 5'd5)  begin errors++; $display("[TB] FAIL man_count: got %0d expected 5", count); end
    mode = 2'b11; arm = 1'b1; rd_en = 1'b1;
    tick();
    arm = 1'b0; rd_en = 1'b0;
    checks += 3;
    if (state !== 2'b01)   begin errors++; $display("[TB] FAIL arm_prio_state: got %0h expected 1", state); end
    if (count !== '0)      begin errors++; $display("[TB] FAIL arm_prio_count: got %0d expected 0", count); end
    if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL arm_prio_valid: got %0b expected 0", rd_valid); end
  endtask

  task automatic test_clk_en();
    for (int i = 0; i < 12; i++) begin
      clk_en = (i % 2 == 0);
      present(1'b1, PC_W'('h200 + i), 4'h0);
    end
    clk_en = 1'b1;
    checks++;
    if (count !== 5'd6) begin errors++; $display("[TB] FAIL en_count: got %0d expected 6", count); end
    stop = 1'b1; tick(); stop = 1'b0;
    rd_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data[PC_W-1:0] !== PC_W'('h200 + 2 * k) || rd_data !== m_exp_data) begin
        errors++; $display("[TB] FAIL en_read%0d: got v=%0b %0h expected pc=%0h", k, rd_valid, rd_data, 'h200 + 2 * k);
      end
      if (k == 2) begin
        clk_en = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL en_hold_valid: got %0b expected 1", rd_valid); end
        clk_en = 1'b1;
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_post();
    trig_pc = 16'h0003;
    do_arm(2'b00, 4'd5);
    for (int p = 0; p <= 4; p++) present(1'b1, PC_W'(p), 4'h0);
    checks++;
    if (state !== 2'b10) begin errors++; $display("[TB] FAIL post_state: got %0h expected 2", state); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (state !== 2'b00)   begin errors++; $display("[TB] FAIL rst_async_state: got %0h expected 0", state); end
    if (count !== '0)      begin errors++; $display("[TB] FAIL rst_async_count: got %0d expected 0", count); end
    if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_valid: got %0b expected 0", rd_valid); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      trig_pc = PC_W'($urandom_range(0, 31));
      mask    = FLAG_W'($urandom());
      do_arm(2'($urandom_range(0, 2)), AW'($urandom()));
      for (int c = 0; c < 80 && m_state != 3; c++) begin
        stop = (c == 70);
        present($urandom_range(0, 3) != 0, PC_W'($urandom_range(0, 31)), FLAG_W'($urandom()));
        stop = 1'b0;
      end
      checks += 2;
      if (state !== 2'b11) begin errors++; $display("[TB] FAIL rnd%0d_state: got %0h expected 3", it, state); end
      if (count !== (AW+1)'(m_q.size())) begin
        errors++; $display("[TB] FAIL rnd%0d_count: got %0d expected %0d", it, count, m_q.size());
      end
      n = m_q.size();
      rd_en = 1'b1;
      for (int k = 0; k <= n; k++) begin
        tick();
        checks++;
        if (rd_valid !== m_exp_valid || (m_exp_valid && rd_data !== m_exp_data)) begin
          errors++;
          $display("[TB] FAIL rnd%0d_read%0d: got v=%0b %0h expected v=%0b %0h", it, k, rd_valid, rd_data, m_exp_valid, m_exp_data);
        end
      end
      rd_en = 1'b0;
      tick();
    end
  endtask

  initial begin
    clk_en = 1'b1; arm = 1'b0; stop = 1'b0; valid = 1'b0; rd_en = 1'b0;
    mode = 2'b00; trig_pc = '0; mask = '0; post = '0; pc = '0; flags = '0; instr = '0;
    test_reset();
    test_mode_immediate();
    test_mode_pc_wrap();
    test_mode_flag();
    test_manual_and_arm_priority();
    test_clk_en();
    test_reset_mid_post();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
